sdram_req_bridge: RTL

- Parametrised successor to the single-channel edge-detect SDRAM requester in the MiST top level.
- Accepts NCH asynchronous-style memory buses (cs/oe/we/addr/data), for example the CPU, a tape loader and a video fetcher.
- Detects new accesses on each bus and arbitrates them round-robin onto one toggle-handshake SDRAM port (req/ack toggle).
- Returns read data per channel, with per-channel busy flags and an optional ack timeout.

---
 rtl/sdram_req_bridge.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_req_bridge.sv
// sdram_req_bridge: detects new accesses on NCH asynchronous-style client
// buses, arbitrates them round-robin onto a single toggle-handshake SDRAM port
// and returns read data per channel. Optional ack timeout with a sticky flag.
module sdram_req_bridge #(
   parameter int NCH       = 2,
   parameter int AW        = 16,
   parameter int DW        = 8,
   parameter int TO_CYCLES = 0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [NCH-1:0]    ch_cs,
   input  logic [NCH-1:0]    ch_oe,
   input  logic [NCH-1:0]    ch_we,
   input  logic [NCH*AW-1:0] ch_a,
   input  logic [NCH*DW-1:0] ch_d,
   output logic [NCH*DW-1:0] ch_q,
   output logic [NCH-1:0]    ch_busy,
   output logic              sd_req,
   input  logic              sd_ack,
   output logic [AW-1:0]     sd_a,
   output logic              sd_we,
   output logic [1:0]        sd_ds,
   output logic [15:0]       sd_d,
   input  logic [15:0]       sd_q,
   output logic              sd_timeout
);

   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TO_LIMIT = TW'(TO_CYCLES);
   localparam logic [GW-1:0] LAST_INIT = GW'(NCH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // Round-robin search: first set bit of req starting at last+1 (mod NCH).
   // Returns {found, index}.
   function automatic logic [GW:0] rr_pick(input logic [NCH-1:0] req,
                                           input logic [GW-1:0]  last);
      logic [GW:0] res;
      int          idx;
      res = {1'b0, {GW{1'b0}}};
      // Walk from farthest to nearest so the nearest candidate is kept last.
      for (int k = NCH; k >= 1; k--) begin
         idx = (int'(last) + k) % NCH;
         if (req[idx]) begin
            res = {1'b1, GW'(idx)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Byte-lane select for an 8-bit client: writes hit one lane, reads take both.
   function automatic logic [1:0] lane_sel(input logic we, input logic a0);
      logic [1:0] ds;
      if (DW == 8 && we) begin
         ds = a0 ? 2'b10 : 2'b01;
      end else begin
         ds = 2'b11;
      end
      return ds;
   endfunction

   // Per-channel access-detect history and captured request slots.
   logic [NCH-1:0] rd_old_r;
   logic [NCH-1:0] wr_old_r;
   logic [AW-1:0]  a_old_r   [NCH];
   logic [AW-1:0]  slot_a_r  [NCH];
   logic           slot_we_r [NCH];
   logic [DW-1:0]  slot_d_r  [NCH];
   logic [NCH-1:0] pending_r;

   // Arbiter state.
   state_t         state_r;
   logic [GW-1:0]  grant_r;
   logic [GW-1:0]  last_grant_r;
   logic [TW-1:0]  to_cnt_r;

   logic [NCH-1:0] rd_s;
   logic [NCH-1:0] wr_s;
   logic [NCH-1:0] trig_s;
   logic [GW:0]    pick_s;
   logic           ack_match_s;
   logic [1:0]     issue_ds_s;
   logic [15:0]    issue_d_s;
   logic [DW-1:0]  rd_data_s;

   // New-access detection: rising read/write strobe, or address change during a read.
   always_comb begin
      rd_s   = {NCH{1'b0}};
      wr_s   = {NCH{1'b0}};
      trig_s = {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         rd_s[i]   = ch_cs[i] & ch_oe[i];
         wr_s[i]   = ch_cs[i] & ch_we[i];
         trig_s[i] = (rd_s[i] & ~rd_old_r[i]) |
                     (wr_s[i] & ~wr_old_r[i]) |
                     (rd_s[i] & (ch_a[i*AW +: AW] != a_old_r[i]));
      end
   end

   // Arbitration pick, handshake match and lane/data formatting of the granted slot.
   always_comb begin
      pick_s      = rr_pick(pending_r, last_grant_r);
      ack_match_s = (sd_ack == sd_req);
      issue_ds_s  = lane_sel(slot_we_r[grant_r], slot_a_r[grant_r][0]);
   end

   generate
      if (DW == 8) begin : g_byte
         assign issue_d_s = {slot_d_r[grant_r], slot_d_r[grant_r]};
         assign rd_data_s = sd_a[0] ? sd_q[15:8] : sd_q[7:0];
      end else begin : g_word
         assign issue_d_s = slot_d_r[grant_r];
         assign rd_data_s = sd_q;
      end
   endgenerate

   // Busy while queued, or while this channel owns the in-progress transfer.
   always_comb begin
      ch_busy = {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         ch_busy[i] = pending_r[i] | ((state_r != ST_IDLE) && (grant_r == GW'(i)));
      end
   end

   // Strobe history, slot capture and pending flags; a fresh trigger beats the issue clear.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rd_old_r  <= {NCH{1'b0}};
         wr_old_r  <= {NCH{1'b0}};
         pending_r <= {NCH{1'b0}};
         for (int i = 0; i < NCH; i++) begin
            a_old_r[i]   <= {AW{1'b0}};
            slot_a_r[i]  <= {AW{1'b0}};
            slot_we_r[i] <= 1'b0;
            slot_d_r[i]  <= {DW{1'b0}};
         end
      end else begin
         rd_old_r <= rd_s;
         wr_old_r <= wr_s;
         for (int i = 0; i < NCH; i++) begin
            a_old_r[i] <= ch_a[i*AW +: AW];
            if (trig_s[i]) begin
               pending_r[i] <= 1'b1;
               slot_a_r[i]  <= ch_a[i*AW +: AW];
               slot_we_r[i] <= ch_we[i];
               slot_d_r[i]  <= ch_d[i*DW +: DW];
            end else if (state_r == ST_ISSUE && grant_r == GW'(i)) begin
               pending_r[i] <= 1'b0;
            end
         end
      end
   end

   // Arbiter FSM: grant, issue on the SDRAM port, then wait for ack or timeout.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         grant_r      <= {GW{1'b0}};
         last_grant_r <= LAST_INIT;
         to_cnt_r     <= {TW{1'b0}};
         sd_req       <= 1'b0;
         sd_a         <= {AW{1'b0}};
         sd_we        <= 1'b0;
         sd_ds        <= 2'b00;
         sd_d         <= 16'h0000;
         ch_q         <= {(NCH*DW){1'b0}};
         sd_timeout   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // A desynchronised handshake (ack != req) blocks new issues.
               if (pick_s[GW] && ack_match_s) begin
                  grant_r <= pick_s[GW-1:0];
                  state_r <= ST_ISSUE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               sd_a         <= slot_a_r[grant_r];
               sd_we        <= slot_we_r[grant_r];
               sd_ds        <= issue_ds_s;
               sd_d         <= issue_d_s;
               sd_req       <= ~sd_req;
               last_grant_r <= grant_r;
               to_cnt_r     <= {TW{1'b0}};
               state_r      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (ack_match_s) begin
                  if (!sd_we) begin
                     ch_q[int'(grant_r)*DW +: DW] <= rd_data_s;
                  end
                  state_r <= ST_IDLE;
               end else if (TO_CYCLES > 0 && to_cnt_r == TO_LIMIT) begin
                  sd_timeout <= 1'b1;
                  state_r    <= ST_IDLE;
               end else begin
                  to_cnt_r <= to_cnt_r + TW'(1);
                  state_r  <= ST_WAIT;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
